// File: rtl/multi_channel_blinker_pkg.sv
// multi_channel_blinker shared definitions
// state encodings and default widths
package multi_channel_blinker_pkg;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PULSE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

endpackage

// File: rtl/multi_channel_blinker_if.sv
// multi_channel_blinker control/status bundle
// packed per-channel buses, ch i at [i*W +: W]
interface multi_channel_blinker_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 8
);

  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH*CNT_W-1:0]   on_time;
  logic [NUM_CH*CNT_W-1:0]   off_time;
  logic [NUM_CH*PULSE_W-1:0] pulses;
  logic [NUM_CH-1:0]         out;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         done;

  modport master (
    output start, stop, on_time, off_time, pulses,
    input  out, busy, done
  );

  modport slave (
    input  start, stop, on_time, off_time, pulses,
    output out, busy, done
  );

endinterface

// File: rtl/multi_channel_blinker_channel.sv
// multi_channel_blinker single channel
// IDLE/ON/OFF FSM with phase and burst counters
module multi_channel_blinker_channel
  import multi_channel_blinker_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   on_time,
  input  logic [CNT_W-1:0]   off_time,
  input  logic [PULSE_W-1:0] pulses,
  output logic               out,
  output logic               busy,
  output logic               done
);

  state_t             state, st_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PULSE_W-1:0] rem, rem_n;
  logic [CNT_W-1:0]   on_q, on_n;
  logic [CNT_W-1:0]   off_q, off_n;
  logic               burst_q, burst_n;
  logic               done_n;

  // a zero duration behaves as one cycle
  function automatic logic [CNT_W-1:0] phase_len(
    input logic [CNT_W-1:0] d
  );
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  // state, counters, latched config, registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rem     <= '0;
      on_q    <= '0;
      off_q   <= '0;
      burst_q <= 1'b0;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= st_n;
      cnt     <= cnt_n;
      rem     <= rem_n;
      on_q    <= on_n;
      off_q   <= off_n;
      burst_q <= burst_n;
      out     <= (st_n == ST_ON);
      busy    <= (st_n != ST_IDLE);
      done    <= done_n;
    end
  end

  // next state; stop overrides everything
  always_comb begin
    st_n    = state;
    cnt_n   = cnt;
    rem_n   = rem;
    on_n    = on_q;
    off_n   = off_q;
    burst_n = burst_q;
    done_n  = 1'b0;
    if (stop) begin
      st_n = ST_IDLE;
    end else begin
      case (state)
        ST_ON: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (burst_q &&
                       rem == PULSE_W'(1)) begin
            st_n   = ST_IDLE;
            done_n = 1'b1;
          end else begin
            st_n  = ST_OFF;
            cnt_n = phase_len(off_q);
            if (burst_q)
              rem_n = rem - PULSE_W'(1);
          end
        end
        ST_OFF: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else begin
            st_n  = ST_ON;
            cnt_n = phase_len(on_q);
          end
        end
        default: begin
          st_n = ST_IDLE;
          if (start) begin
            st_n    = ST_ON;
            cnt_n   = phase_len(on_time);
            rem_n   = pulses;
            on_n    = on_time;
            off_n   = off_time;
            burst_n = (pulses != '0);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_blinker.sv
// multi_channel_blinker top
// slices the packed buses across NUM_CH channels
module multi_channel_blinker
  import multi_channel_blinker_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 8
) (
  input logic              clk,
  input logic              reset,
  multi_channel_blinker_if.slave bus
);

  logic [NUM_CH-1:0] out_w;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;

  assign bus.out  = out_w;
  assign bus.busy = busy_w;
  assign bus.done = done_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_channel_blinker_channel #(
      .CNT_W  (CNT_W),
      .PULSE_W(PULSE_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .start   (bus.start[i]),
      .stop    (bus.stop[i]),
      .on_time (bus.on_time[i*CNT_W +: CNT_W]),
      .off_time(bus.off_time[i*CNT_W +: CNT_W]),
      .pulses  (bus.pulses[i*PULSE_W +: PULSE_W]),
      .out     (out_w[i]),
      .busy    (busy_w[i]),
      .done    (done_w[i])
    );
  end

endmodule
